// File: rtl/smvm_pkg.sv
// Shared definitions for the SMVM core and its result collector:
// half-word/result widths, collector state encoding and the result record.
package smvm_pkg;

    localparam int HALF_W = 14;
    localparam int RES_W  = 2 * HALF_W;
    localparam int ROW_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [RES_W-1:0] data;
    } result_t;

endpackage

// File: rtl/smvm_result_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module smvm_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/smvm_result_collector.sv
// Reassembles the core's high/low half-word stream into row-tagged signed
// results, buffers them and hands them to the host over valid/ready.
module smvm_result_collector #(
    parameter int HALF_W = smvm_pkg::HALF_W,
    parameter int RES_W  = smvm_pkg::RES_W,
    parameter int ROW_W  = smvm_pkg::ROW_W,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ROW_W-1:0]        rows_in,
    input  logic                    in_valid,
    input  logic [HALF_W-1:0]       data_in,
    output logic                    res_valid,
    output logic signed [RES_W-1:0] res_data,
    output logic [ROW_W-1:0]        res_row,
    input  logic                    res_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    import smvm_pkg::*;

    state_t              state;
    state_t              state_nxt;
    logic                done_nxt;
    logic [ROW_W-1:0]    rows_exp;
    logic [ROW_W-1:0]    row_cnt;
    logic                half_sel;
    logic [HALF_W-1:0]   hi_half;
    logic                push;
    logic                pop;
    logic                last_row;
    logic                arm;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ROW_W+RES_W-1:0] fifo_wdata;
    logic [ROW_W+RES_W-1:0] fifo_rdata;

    assign push       = (state == COLLECT) && half_sel && in_valid;
    assign pop        = res_valid && res_ready;
    assign last_row   = (row_cnt == rows_exp - ROW_W'(1));
    assign arm        = (state == IDLE) && start;
    assign fifo_wdata = {row_cnt, hi_half, data_in};

    assign res_valid  = !fifo_empty;
    assign res_data   = fifo_rdata[RES_W-1:0];
    assign res_row    = fifo_rdata[ROW_W+RES_W-1 -: ROW_W];
    assign busy       = (state == COLLECT) || (state == DRAIN);

    smvm_result_fifo #(
        .WIDTH (ROW_W + RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (rows_in != '0) begin
                        state_nxt = COLLECT;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (push && last_row) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A dropped push still advances row_cnt so later row tags stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            rows_exp <= '0;
            row_cnt  <= '0;
            half_sel <= 1'b0;
            hi_half  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (arm) begin
                overflow <= 1'b0;
                if (rows_in != '0) begin
                    rows_exp <= rows_in;
                    row_cnt  <= '0;
                    half_sel <= 1'b0;
                end
            end
            if ((state == COLLECT) && in_valid) begin
                half_sel <= ~half_sel;
                if (!half_sel) begin
                    hi_half <= data_in;
                end else begin
                    row_cnt <= row_cnt + ROW_W'(1);
                end
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/smvm_result_collector.md
# smvm_result_collector

Downstream consumer of the SMVM core's serialized result stream. The core emits each 28-bit row result as two consecutive 14-bit half-words, high half first, on `out_valid`/`data_out`, with no backpressure. This block:
- reassembles each pair into a signed 28-bit result tagged with its row index;
- buffers results in a small FIFO;
- presents them to the host through a valid/ready handshake;
- signals completion once the expected number of rows has been delivered.

## Interface
Parameters:
- `HALF_W`, 14: width of one incoming half-word.
- `RES_W`, 28: width of a reassembled result; must equal 2*HALF_W.
- `ROW_W`, 8: width of row count and row index.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1: the block's one clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `start`  in  1: single-cycle pulse that arms a new collection; honoured only in IDLE.
- `rows_in`  in  ROW_W: expected row count, sampled on `start`.
- `in_valid`  in  1: connected to the core's `out_valid`.
- `data_in`  in  HALF_W: connected to the core's `data_out`.
- `res_valid`  out  1: the FIFO head is valid.
- `res_data`  out  RES_W: FIFO head result, signed.
- `res_row`  out  ROW_W: row index of the FIFO head, 0-based.
- `res_ready`  in  1: host accepts the head this cycle.
- `busy`  out  1: high in COLLECT and DRAIN.
- `done`  out  1: one-cycle pulse when a collection completes.
- `overflow`  out  1: sticky flag, a result was dropped; cleared by `start` or reset.

## Operation
States and transitions:
- **IDLE**
  - On `start` with `rows_in` ≠ 0: latch `rows_in`, clear the row counter, half toggle and `overflow`; go to COLLECT.
  - On `start` with `rows_in` = 0: pulse `done` next cycle and stay in IDLE.
  - `in_valid` is ignored in IDLE.
- **COLLECT**
  - Half toggle = 0 and `in_valid`: latch `data_in` as the high half; toggle goes to 1.
  - Half toggle = 1 and `in_valid`: form {hi, `data_in`}; push it with the current row index; increment the row counter; toggle goes to 0.
  - When the pushed row is the last one (row counter = expected − 1): go to DRAIN.
  - `start` is ignored.
- **DRAIN**
  - `in_valid` is ignored; the host keeps popping.
  - When the FIFO is empty: pulse `done` and go to IDLE.

FIFO:
- A pop happens on `res_valid && res_ready`.
- A push is accepted when the FIFO is not full, or when a pop happens in the same cycle.
- Otherwise the push is dropped: `overflow` sets, and the row counter still advances so row indices stay aligned.
- Simultaneous push and pop on an empty FIFO: the pop does not happen (`res_valid` is 0) and the push is stored.
- Read and write pointers are ROW_W-independent, log2(DEPTH)+1 bits wide, and wrap modulo 2*DEPTH. Full and empty are derived from the pointer MSB and LSB comparison.
- `res_data` and `res_row` come straight from storage at the read pointer; there is no combinational path from `data_in`.

Reset: `rst_n` low at a clock edge does the following, including mid-collection; a partial half-word is discarded:
- state to IDLE;
- pointers, counters and toggle to 0;
- `res_valid`, `busy`, `done` and `overflow` to 0.

`res_data` and `res_row` read 0 after reset because storage is cleared.

## Timing
- Latency: a result pushed on the low-half cycle shows `res_valid` = 1 on the next cycle.
- `res_valid` stays high, with stable data, until popped.
- `done` is asserted exactly one cycle after the cycle in which the FIFO becomes empty in DRAIN.
- `busy` drops in the same cycle that `done` rises.
- Back-to-back half-words every cycle are supported indefinitely, provided the host pops at least one result every two cycles.
- An idle gap between the high and low halves is allowed; the toggle holds.

## Structure
- Shared package `smvm_pkg` holds:
  - `HALF_W` and `RES_W` constants, also used by the core's output buffer;
  - the state enum encoding (IDLE, COLLECT, DRAIN);
  - a `result_t` struct {row, data}.
- One natural sub-module, `smvm_result_fifo`: synchronous FIFO, parameterised by width and DEPTH, with push/pop/full/empty.
- The top level holds the FSM, half toggle, row counter and `overflow`.

## Test plan
- **Basic reassembly.** `start`, `rows_in`=2; halves 0x0001, 0x0002, 0x3FFF, 0x3FFE; `res_ready`=1.
  - Results: (row 0, 0x0004002), then (row 1, 0xFFFFFFE), i.e. −2.
  - `done` pulses once.
- **Backpressure and overflow.** DEPTH=8, `res_ready`=0, `rows_in`=10, 10 pairs sent.
  - Exactly 8 results are held, rows 0–7; `overflow` = 1.
  - After raising `res_ready`: 8 pops, then `done`.
- **Full plus pop in the same cycle.** FIFO full, push coincides with a pop.
  - The push is accepted; `overflow` stays 0.
- **Gap between halves.** High half, 5 idle cycles, low half.
  - A correct result; `res_valid` rises one cycle after the low half.
- **Zero rows and ignored inputs.** `start` with `rows_in`=0.
  - `done` on the next cycle; `busy` never rises.
  - `in_valid` pulses in IDLE produce no results.
- **Reset mid-collection.** `rst_n` low after one high half of row 3.
  - All outputs are 0 on the next cycle.
  - A new `start`, `rows_in`=1, then yields row 0 correctly.
